// File: rtl/instrumented_meter_pkg.sv
// Shared types and constants for the instrumented adder meter.
// FSM state encoding, drain length and synchroniser depth.
package instrumented_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    DRAIN
  } state_t;

  localparam int DRAIN_CYC   = 3;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ring_edge_counter.sv
// Ring tap synchroniser, rising-edge detect and saturating edge counter.
// Ports: wb_clk_i, rst_n, ring_in, clr, en -> count, overflow.
module ring_edge_counter
  import instrumented_meter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             ring_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   rise;

  assign rise = sync[SYNC_STAGES-1] & ~prev;

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      sync     <= '0;
      prev     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ring_in};
      prev <= sync[SYNC_STAGES-1];
      if (clr) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (en && rise) begin
        // an edge arriving at full scale is lost: flag it
        if (&count) overflow <= 1'b1;
        else        count    <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instrumented_adder_meter.sv
// Measurement controller: drives adder operands, settles, gates ring, counts.
// Ports: operands/selects in, sum_in/ring_osc from adders, results out.
module instrumented_adder_meter
  import instrumented_meter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 32,
  parameter int WIN_W      = 24,
  parameter int SETTLE_CYC = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [$clog2(NUM_CH)-1:0]   ch_sel,
  input  logic [WIDTH-1:0]            a_in,
  input  logic [WIDTH-1:0]            b_in,
  input  logic [$clog2(WIDTH)-1:0]    ring_sel_in,
  input  logic [WIN_W-1:0]            window,
  input  logic [NUM_CH*(WIDTH+1)-1:0] sum_in,
  input  logic [NUM_CH-1:0]           ring_osc,
  output logic [WIDTH-1:0]            a_out,
  output logic [WIDTH-1:0]            b_out,
  output logic [$clog2(WIDTH)-1:0]    ring_sel,
  output logic [NUM_CH-1:0]           ring_en,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            count,
  output logic                        overflow,
  output logic [WIDTH:0]              sum_out
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int SC_W = $clog2(SETTLE_CYC + 1);
  localparam int DR_W = $clog2(DRAIN_CYC);

  state_t           state;
  logic [CH_W-1:0]  ch_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_cnt;
  logic [SC_W-1:0]  set_cnt;
  logic [DR_W-1:0]  drn_cnt;
  logic [NUM_CH-1:0] ch_oh;
  logic             go;
  logic             cnt_en;

  // done cycle is IDLE but must not retrigger
  assign go     = (state == IDLE) && start && !abort && !done;
  assign cnt_en = (state == COUNT) || (state == DRAIN);
  assign ch_oh  = NUM_CH'(1) << ch_q;

  ring_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .ring_in  (ring_osc[ch_q]),
    .clr      (go),
    .en       (cnt_en),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch_q     <= '0;
      win_q    <= '0;
      win_cnt  <= '0;
      set_cnt  <= '0;
      drn_cnt  <= '0;
      a_out    <= '0;
      b_out    <= '0;
      ring_sel <= '0;
      ring_en  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        ring_en <= '0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (go) begin
              a_out    <= a_in;
              b_out    <= b_in;
              ring_sel <= ring_sel_in;
              win_q    <= window;
              if (32'(ch_sel) >= 32'(NUM_CH))
                ch_q <= CH_W'(NUM_CH - 1);
              else
                ch_q <= ch_sel;
              set_cnt <= SC_W'(SETTLE_CYC - 1);
              busy    <= 1'b1;
              state   <= SETTLE;
            end
          end
          SETTLE: begin
            if (set_cnt == '0) begin
              sum_out <= sum_in[ch_q*(WIDTH+1) +: WIDTH+1];
              if (win_q == '0) begin
                drn_cnt <= DR_W'(DRAIN_CYC - 1);
                state   <= DRAIN;
              end else begin
                win_cnt <= win_q - 1'b1;
                ring_en <= ch_oh;
                state   <= COUNT;
              end
            end else begin
              set_cnt <= set_cnt - 1'b1;
            end
          end
          COUNT: begin
            if (win_cnt == '0) begin
              ring_en <= '0;
              drn_cnt <= DR_W'(DRAIN_CYC - 1);
              state   <= DRAIN;
            end else begin
              win_cnt <= win_cnt - 1'b1;
            end
          end
          DRAIN: begin
            if (drn_cnt == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              drn_cnt <= drn_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instrumented_adder_meter.sv
// Self-checking bench for instrumented_adder_meter.
// Runs a 32-bit and a 4-bit-counter instance in lockstep.
module tb_instrumented_adder_meter;

  localparam int WIDTH      = 32;
  localparam int WIN_W      = 24;
  localparam int SETTLE_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [0:0]  ch_sel = '0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [4:0]  ring_sel_in = '0;
  logic [23:0] window = '0;
  logic [65:0] sum_in;
  logic [65:0] s_sum_in;
  logic [1:0]  ring_osc = 2'b00;

  logic [31:0] a_out, b_out, s_a_out, s_b_out;
  logic [4:0]  ring_sel, s_ring_sel;
  logic [1:0]  ring_en, s_ring_en;
  logic        busy, done, overflow;
  logic        s_busy, s_done, s_overflow;
  logic [31:0] count;
  logic [3:0]  s_count;
  logic [32:0] sum_out, s_sum_out;

  int nvec = 0;
  int nmis = 0;

  int         ring_half = 2;
  int         ph[2] = '{0, 0};
  int         gen_edges[2] = '{0, 0};
  logic [1:0] noise = 2'b00;
  logic [1:0] mute = 2'b00;

  // adders under test: channel 1 correct, channel 0 has a stuck LSB flip
  function automatic logic [65:0] adders(input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s, s ^ 33'd1};
  endfunction

  assign sum_in   = adders(a_out, b_out);
  assign s_sum_in = adders(s_a_out, s_b_out);

  always #5 clk = ~clk;

  // ring oscillator model: toggles while gated on, counts its rising edges
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if ((ring_en[c] && !mute[c]) || noise[c]) begin
        ph[c]++;
        if (ph[c] >= ring_half) begin
          ph[c] = 0;
          ring_osc[c] = ~ring_osc[c];
          if (ring_osc[c]) gen_edges[c]++;
        end
      end
    end
  end

  instrumented_adder_meter u_dut (
    .wb_clk_i (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .ch_sel (ch_sel), .a_in (a_in), .b_in (b_in),
    .ring_sel_in (ring_sel_in), .window (window),
    .sum_in (sum_in), .ring_osc (ring_osc),
    .a_out (a_out), .b_out (b_out), .ring_sel (ring_sel),
    .ring_en (ring_en), .busy (busy), .done (done),
    .count (count), .overflow (overflow), .sum_out (sum_out)
  );

  instrumented_adder_meter #(.CNT_W(4)) u_sat (
    .wb_clk_i (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .ch_sel (ch_sel), .a_in (a_in), .b_in (b_in),
    .ring_sel_in (ring_sel_in), .window (window),
    .sum_in (s_sum_in), .ring_osc (ring_osc),
    .a_out (s_a_out), .b_out (s_b_out), .ring_sel (s_ring_sel),
    .ring_en (s_ring_en), .busy (s_busy), .done (s_done),
    .count (s_count), .overflow (s_overflow), .sum_out (s_sum_out)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [0:0]  ch;
    logic [4:0]  rs;
    int          win;
    int          per;
    logic [32:0] exp_sum;
    int          exp_lat;
    logic [1:0]  nz;
    logic [1:0]  mt;
  } vec_t;

  task automatic run_meas(input vec_t v);
    int         lat, en_cyc, bad_en, ec;
    logic [1:0] oh;
    oh = 2'b01 << v.ch;
    ring_half = v.per / 2;
    noise = v.nz;
    mute = v.mt;
    gen_edges[0] = 0;
    gen_edges[1] = 0;
    a_in = v.a; b_in = v.b; ch_sel = v.ch;
    ring_sel_in = v.rs; window = WIN_W'(v.win);
    start = 1'b1;
    step();
    start = 1'b0;
    // scramble inputs: the latched copies must not follow
    a_in = ~v.a; b_in = ~v.b; ch_sel = ~v.ch;
    ring_sel_in = ~v.rs; window = 24'd3;
    chk("busy_on", 64'(busy), 64'd1);
    chk("a_out", 64'(a_out), 64'(v.a));
    chk("b_out", 64'(b_out), 64'(v.b));
    chk("ring_sel", 64'(ring_sel), 64'(v.rs));
    chk("count_clr", 64'({overflow, count}), 64'd0);
    chk("sat_clr", 64'({s_overflow, s_count}), 64'd0);
    lat = 1; en_cyc = 0; bad_en = 0;
    while (!done && lat < v.exp_lat + 20) begin
      if (ring_en == oh) en_cyc++;
      else if (ring_en != 2'b00) bad_en++;
      start = (lat == 2);
      step();
      lat++;
    end
    start = 1'b0;
    ec = gen_edges[v.ch];
    chk("latency", 64'(lat), 64'(v.exp_lat));
    chk("ring_en_cycles", 64'(en_cyc), 64'(v.win));
    chk("ring_en_wrong", 64'(bad_en), 64'd0);
    chk("sum_out", 64'(sum_out), 64'(v.exp_sum));
    chk("count", 64'(count), 64'(ec));
    chk("overflow", 64'(overflow), 64'd0);
    chk("sat_count", 64'(s_count), 64'(ec > 15 ? 15 : ec));
    chk("sat_overflow", 64'(s_overflow), 64'(ec > 15));
    chk("a_hold", 64'(a_out), 64'(v.a));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("start_on_done_ignored", 64'(busy), 64'd0);
    noise = 2'b00;
    mute = 2'b00;
  endtask

  vec_t tv[5];

  initial begin
    int seen;
    int w;
    vec_t rv;

    tv[0] = '{a:32'd5, b:32'd3, ch:1'b1, rs:5'd3, win:100, per:4,
              exp_sum:33'd8, exp_lat:108, nz:2'b00, mt:2'b00};
    tv[1] = '{a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, ch:1'b1, rs:5'd31,
              win:0, per:4, exp_sum:33'h1_FFFF_FFFE, exp_lat:8,
              nz:2'b00, mt:2'b00};
    tv[2] = '{a:32'd1, b:32'd2, ch:1'b1, rs:5'd7, win:64, per:2,
              exp_sum:33'd3, exp_lat:72, nz:2'b00, mt:2'b00};
    tv[3] = '{a:32'd10, b:32'd20, ch:1'b0, rs:5'd1, win:7, per:2,
              exp_sum:33'd31, exp_lat:15, nz:2'b00, mt:2'b00};
    tv[4] = '{a:32'd7, b:32'd9, ch:1'b1, rs:5'd9, win:50, per:2,
              exp_sum:33'd16, exp_lat:58, nz:2'b01, mt:2'b10};

    // reset with rings toggling
    noise = 2'b11;
    repeat (5) step();
    chk("rst_ab", {a_out, b_out}, 64'd0);
    chk("rst_ctl", 64'({ring_sel, ring_en, busy, done, overflow}), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_sat", 64'({s_ring_en, s_busy, s_done, s_count, s_overflow}),
        64'd0);
    noise = 2'b00;
    rst_n = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 5; i++) run_meas(tv[i]);

    // abort in the middle of COUNT
    a_in = 32'd1; b_in = 32'd1; ch_sel = 1'b1; window = 24'd100;
    ring_half = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (ring_en == 2'b00 && w < 20) begin
      step();
      w++;
    end
    chk("abort_reached_count", 64'(ring_en), 64'd2);
    repeat (20) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ring_off", 64'(ring_en), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      if (done) seen++;
      step();
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_sum_kept", 64'(sum_out), 64'd2);
    chk("abort_count_kept", 64'(count != 0), 64'd1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", 64'(busy), 64'd0);

    // randomized measurements against the model
    for (int i = 0; i < 8; i++) begin
      rv.a = $urandom;
      rv.b = $urandom;
      rv.ch = 1'($urandom_range(0, 1));
      rv.rs = 5'($urandom_range(0, 31));
      rv.win = $urandom_range(0, 40);
      rv.per = $urandom_range(2, 9);
      rv.exp_sum = {1'b0, rv.a} + {1'b0, rv.b};
      if (rv.ch == 1'b0) rv.exp_sum = rv.exp_sum ^ 33'd1;
      rv.exp_lat = 1 + SETTLE_CYC + rv.win + 3;
      rv.nz = 2'b00;
      rv.mt = 2'b00;
      run_meas(rv);
    end

    // reset in the middle of a measurement
    a_in = 32'd4; b_in = 32'd4; ch_sel = 1'b1; window = 24'd50;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    rst_n = 1'b0;
    step();
    chk("midrst_ctl", 64'({ring_en, busy, done}), 64'd0);
    chk("midrst_data", 64'({count, overflow}), 64'd0);
    chk("midrst_sum", 64'(sum_out), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
